// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Entries in the output buffer pair each instruction word with its fetch PC.
package fetch_stage_pkg;

  localparam int          INSTR_W          = 32;
  localparam int          PC_W             = 32;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Instructions are word aligned; low address bits of a target are dropped.
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] addr);
    return addr & ~(PC_W'(3));
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer of fetched {pc, instr} entries with a combinational head.
// clear wins over push and pop, so a flush can never be undone by a late response.
module fetch_fifo
  import fetch_stage_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output fetch_entry_t     head
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    do_push  = push & ~clear;
    do_pop   = pop & ~clear & (count_q != '0);
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is reset so the head reads zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues 1-cycle-latency imem reads and
// buffers responses so the downstream handshake can stall without losing words.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      inflight_pc_q, inflight_pc_d;
  logic             inflight_q, inflight_d;
  logic [CNT_W-1:0] fifo_count;
  fetch_entry_t     fifo_head;
  fetch_entry_t     push_entry;
  logic             pop;
  logic             push;
  logic [OCC_W-1:0] occupancy;

  assign out_valid  = (fifo_count != '0);
  assign out_pc     = fifo_head.pc;
  assign out_instr  = fifo_head.instr;
  assign imem_addr  = pc_q;
  assign push_entry = '{pc: inflight_pc_q, instr: imem_rdata};

  // Credit check counts the word still in flight and the slot freed by this
  // cycle's pop, which keeps 1 instr/cycle throughput without overflow.
  always_comb begin
    pop           = out_valid & out_ready & ~redirect_valid;
    occupancy     = OCC_W'(fifo_count) + OCC_W'(inflight_q) - OCC_W'(pop);
    imem_en       = ~redirect_valid & (occupancy < OCC_W'(BUF_DEPTH));
    push          = inflight_q & ~redirect_valid;
    pc_d          = pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    if (redirect_valid) begin
      pc_d       = align_pc(redirect_pc);
      inflight_d = 1'b0;
    end else begin
      inflight_d = imem_en;
      if (imem_en) begin
        inflight_pc_d = pc_q;
        pc_d          = pc_q + PC_STEP;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH(BUF_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_data(push_entry),
    .pop      (pop),
    .clear    (redirect_valid),
    .count    (fifo_count),
    .head     (fifo_head)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed and randomized checks of fetch_stage against a program-order model:
// the stream after reset/redirect must be target, target+4, ... with no gaps.
module tb_fetch_stage;

  localparam int          BUF_DEPTH = 2;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_pc = RESET_PC;
  int          outstanding = 0;
  int          since_flush = 100;

  always #5 clk = ~clk;

  fetch_stage #(
    .RESET_PC (RESET_PC),
    .BUF_DEPTH(BUF_DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_en       (imem_en),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_instr     (out_instr)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  always @(posedge clk) begin
    if (imem_en) imem_rdata <= mem_word(imem_addr);
  end

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp_v);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %b required %b", tag, obs, exp_v);
    end
  endtask

  // Called once per cycle between edges: compare the head against the model,
  // then advance the model by whatever the coming clock edge will do.
  task automatic sb();
    logic xfer;
    if (redirect_valid) check1("redirect_no_issue", imem_en, 1'b0);
    if (since_flush == 1 || since_flush == 2) check1("flush_bubble", out_valid, 1'b0);
    if (out_valid) begin
      check32("head_pc", out_pc, exp_pc);
      check32("head_instr", out_instr, mem_word(exp_pc));
    end
    xfer = out_valid && out_ready && !redirect_valid;
    if (xfer) $display("xfer pc=%h instr=%h", out_pc, out_instr);
    if (redirect_valid) begin
      exp_pc      = {redirect_pc[31:2], 2'b00};
      outstanding = 0;
      since_flush = 0;
    end else begin
      outstanding = outstanding + int'(imem_en) - int'(xfer);
      if (xfer) exp_pc = exp_pc + 32'd4;
    end
    check1("buffer_bound", outstanding <= BUF_DEPTH, 1'b1);
    if (since_flush < 100) since_flush++;
  endtask

  task automatic drive(input logic rdy, input logic rv, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(negedge clk);
    sb();
  endtask

  task automatic release_and_check();
    @(negedge clk);
    rst_n          = 1'b1;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    exp_pc         = RESET_PC;
    outstanding    = 0;
    since_flush    = 100;
    #1;
    check1("release_issue", imem_en, 1'b1);
    check32("release_addr", imem_addr, RESET_PC);
    sb();
    drive(1'b1, 1'b0, 32'h0);
    check1("release_bubble", out_valid, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 32'h0);
      check1("startup_valid", out_valid, 1'b1);
      check32("startup_pc", out_pc, RESET_PC + 32'(4 * k));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] wrap_exp [4];
    logic        seen;
    int          lat;
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;

    wrap_exp[0] = 32'hFFFF_FFF8;
    wrap_exp[1] = 32'hFFFF_FFFC;
    wrap_exp[2] = 32'h0000_0000;
    wrap_exp[3] = 32'h0000_0004;

    rst_n          = 1'b0;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    // Reset held for 3 cycles
    repeat (3) begin
      @(negedge clk);
      check1("rst_out_valid", out_valid, 1'b0);
      check32("rst_imem_addr", imem_addr, RESET_PC);
      check32("rst_out_pc", out_pc, 32'h0);
      check32("rst_out_instr", out_instr, 32'h0);
    end
    release_and_check();

    // Stall for 6 cycles: buffer fills, issue stops
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, 32'h0);
      if (i >= 1) begin
        check1("stall_no_issue", imem_en, 1'b0);
        check1("stall_valid", out_valid, 1'b1);
      end
    end
    // Release: one instruction per cycle, no gap
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 32'h0);
      check1("release_no_gap", out_valid, 1'b1);
    end

    // Redirect to a misaligned target while the buffer is full
    repeat (3) drive(1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 32'h0000_0103);
    drive(1'b1, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 32'h0);
    check1("redir_first_valid", out_valid, 1'b1);
    check32("redir_first_pc", out_pc, 32'h0000_0100);
    drive(1'b1, 1'b0, 32'h0);
    check32("redir_second_pc", out_pc, 32'h0000_0104);

    // Redirect in the same cycle as an otherwise-accepted handshake
    repeat (3) drive(1'b1, 1'b0, 32'h0);
    check1("simul_pre_valid", out_valid, 1'b1);
    drive(1'b1, 1'b1, 32'h0000_2000);
    seen = 1'b0;
    lat  = 0;
    for (int k = 1; k <= 8 && !seen; k++) begin
      drive(1'b1, 1'b0, 32'h0);
      if (out_valid) begin
        seen = 1'b1;
        lat  = k;
      end
    end
    check1("simul_seen", seen, 1'b1);
    check32("simul_latency", 32'(lat), 32'd3);
    check32("simul_target_pc", out_pc, 32'h0000_2000);

    // Address wrap-around
    drive(1'b1, 1'b1, 32'hFFFF_FFF8);
    drive(1'b1, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0, 32'h0);
      check1("wrap_valid", out_valid, 1'b1);
      check32("wrap_pc", out_pc, wrap_exp[k]);
    end

    // Back-to-back redirects: last one wins
    drive(1'b1, 1'b1, 32'h0000_0500);
    drive(1'b1, 1'b1, 32'h0000_0600);
    drive(1'b1, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 32'h0);
    check1("b2b_valid", out_valid, 1'b1);
    check32("b2b_pc", out_pc, 32'h0000_0600);

    // Asynchronous reset in the middle of streaming
    repeat (3) drive(1'b1, 1'b0, 32'h0);
    check1("midrst_pre_valid", out_valid, 1'b1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check1("midrst_out_valid", out_valid, 1'b0);
    check32("midrst_imem_addr", imem_addr, RESET_PC);
    check32("midrst_out_pc", out_pc, 32'h0);
    @(negedge clk);
    release_and_check();

    // Randomized ready/redirect traffic
    for (int i = 0; i < 400; i++) begin
      rdy = ($urandom_range(3) != 0);
      rv  = ($urandom_range(24) == 0);
      rpc = ($urandom_range(1) == 1) ? $urandom : (32'hFFFF_FFF0 | 32'($urandom_range(15)));
      drive(rdy, rv, rpc);
    end
    repeat (4) drive(1'b1, 1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
